// File: rtl/regfile_access_master.sv
// ---------------------------------------------------------------------------
// regfile_access_master
//
// Initiator side of one register file port. It turns a valid/ready request
// stream into single register accesses and returns each result through a
// one-entry response register.
//
// Ops:
//   READ    : return the register value.
//   WRITE   : write the request data and return the old value.
//   RMW_ADD : read, add the request data (wrapping), write back, and return
//             the old value.
//
// Ports:
//   clk_i, reset_i          clock and synchronous active-high reset
//   req_valid_i/ready_o     request handshake
//   req_op_i                00 READ, 01 WRITE, 10 RMW_ADD, 11 reserved
//   req_addr_i              binary register index
//   req_data_i              write data or addend
//   rsp_valid_o/ready_i     response handshake
//   rsp_data_o              register value before the access
//   rsp_error_o             address out of range or reserved op
//   rf_register_select_o    one-hot register select to the register file
//   rf_write_select_o       write strobe to the register file
//   rf_data_o               write data to the register file
//   rf_data_i               combinational read data from the register file
//
// Every output comes straight from a flop. There is no input-to-output path.
// ---------------------------------------------------------------------------
module regfile_access_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 4,
   parameter int ADDR_WIDTH    = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [1:0]               req_op_i,
   input  logic [ADDR_WIDTH-1:0]    req_addr_i,
   input  logic [DATA_WIDTH-1:0]    req_data_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DATA_WIDTH-1:0]    rsp_data_o,
   output logic                     rsp_error_o,
   output logic [NUM_REGISTERS-1:0] rf_register_select_o,
   output logic                     rf_write_select_o,
   output logic [DATA_WIDTH-1:0]    rf_data_o,
   input  logic [DATA_WIDTH-1:0]    rf_data_i
);

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_WRITE   = 2'b01,
      OP_RMW_ADD = 2'b10,
      OP_RSVD    = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WB
   } state_e;

   // The register count at address width plus one bit, so an address equal to
   // 2**ADDR_WIDTH could still be compared without wrapping.
   localparam logic [ADDR_WIDTH:0] NUM_REGS_C = NUM_REGISTERS[ADDR_WIDTH:0];

   state_e                   state_q, state_d;
   op_e                      op_q, op_d;
   logic                     err_q, err_d;
   logic [DATA_WIDTH-1:0]    operand_q, operand_d;
   logic [NUM_REGISTERS-1:0] sel_q, sel_d;
   logic                     we_q, we_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
   logic                     rsp_error_q, rsp_error_d;
   logic                     req_ready_q, req_ready_d;

   logic                     accept;
   logic                     req_err;
   logic [NUM_REGISTERS-1:0] req_onehot;

   assign accept  = req_valid_i && req_ready_q;
   assign req_err = ({1'b0, req_addr_i} >= NUM_REGS_C) || (req_op_i == OP_RSVD);

   always_comb begin
      req_onehot = '0;
      for (int i = 0; i < NUM_REGISTERS; i++) begin
         req_onehot[i] = (req_addr_i == ADDR_WIDTH'(i));
      end
   end

   // ---------------------------------------------------------------------
   // State register. All of the block's flops live here.
   // ---------------------------------------------------------------------
   // NOTE: the reset is synchronous, so it is tested inside the clocked
   // block and is not in the sensitivity list. Non-blocking assignments
   // make every flop capture values from before the edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         err_q       <= 1'b0;
         operand_q   <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         err_q       <= err_d;
         operand_q   <= operand_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
         req_ready_q <= req_ready_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every signal assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (accept) state_d = ST_ACCESS;
         // Only a legal RMW_ADD needs the extra writeback cycle.
         ST_ACCESS: state_d = (op_q == OP_RMW_ADD && !err_q) ? ST_WB : ST_IDLE;
         ST_WB:     state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output and datapath next values
   // ---------------------------------------------------------------------
   always_comb begin
      op_d        = op_q;
      err_d       = err_q;
      operand_d   = operand_q;
      sel_d       = sel_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;

      if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            we_d  = 1'b0;
            if (accept) begin
               op_d      = op_e'(req_op_i);
               err_d     = req_err;
               operand_d = req_data_i;
               // An illegal access never touches the register file.
               if (!req_err) begin
                  sel_d = req_onehot;
                  if (req_op_i == OP_WRITE) begin
                     we_d    = 1'b1;
                     wdata_d = req_data_i;
                  end
               end
            end
         end

         ST_ACCESS: begin
            // rf_data_i holds the pre-access value here. A WRITE commits on
            // the same edge that captures it.
            rsp_data_d = err_q ? '0 : rf_data_i;
            if (op_q == OP_RMW_ADD && !err_q) begin
               // Keep the select and strobe the sum during writeback.
               wdata_d = rf_data_i + operand_q;
               we_d    = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_error_d = err_q;
               sel_d       = '0;
               we_d        = 1'b0;
            end
         end

         ST_WB: begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b0;
            sel_d       = '0;
            we_d        = 1'b0;
         end

         default: ;
      endcase

      // Ready is registered. It reflects the state and response occupancy
      // that will hold after this edge.
      req_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
   end

   assign req_ready_o          = req_ready_q;
   assign rsp_valid_o          = rsp_valid_q;
   assign rsp_data_o           = rsp_data_q;
   assign rsp_error_o          = rsp_error_q;
   assign rf_register_select_o = sel_q;
   assign rf_write_select_o    = we_q;
   assign rf_data_o            = wdata_q;

endmodule
